// File: rtl/fpadd_sched.sv
// fpadd_sched: two-requester front end for a shared multi-stage FP adder.
// Grants one operand pair at a time round-robin, steps the datapath stage
// enables one per cycle, then holds the tagged result until the consumer
// takes it.
// Optional feature: define FPADD_SCHED_OPCOUNT_EN to build the saturating
// completed-operation counter. Without it op_count is tied to zero.
module fpadd_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic        en_mask,
  output logic        en_align,
  output logic        en_alu,
  output logic        en_normal,
  output logic        en_pack,
  input  logic [31:0] dp_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [15:0] op_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MASK   = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_ALU    = 3'd3;
  localparam logic [2:0] S_NORMAL = 3'd4;
  localparam logic [2:0] S_PACK   = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  logic [2:0] state, state_nxt;
  logic       last_grant;
  logic       grant0, grant1;

  // Round-robin grant: on a tie the port not served last wins; only in IDLE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE) begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign en_mask   = (state == S_MASK);
  assign en_align  = (state == S_ALIGN);
  assign en_alu    = (state == S_ALU);
  assign en_normal = (state == S_NORMAL);
  assign en_pack   = (state == S_PACK);
  assign rsp_valid = (state == S_RESP);

  // Next-state: fixed one-cycle walk through the stages, wait in RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (grant0 || grant1) state_nxt = S_MASK;
      S_MASK:   state_nxt = S_ALIGN;
      S_ALIGN:  state_nxt = S_ALU;
      S_ALU:    state_nxt = S_NORMAL;
      S_NORMAL: state_nxt = S_PACK;
      S_PACK:   state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Accept: latch the granted pair and its id; they stay put until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_a       <= '0;
      dp_b       <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant0 || grant1) begin
      dp_a       <= grant1 ? req1_a : req0_a;
      dp_b       <= grant1 ? req1_b : req0_b;
      rsp_id     <= grant1;
      last_grant <= grant1;
    end
  end

  // Capture the packed result as the datapath leaves PACK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                rsp_result <= '0;
    else if (state == S_PACK) rsp_result <= dp_result;
  end

`ifdef FPADD_SCHED_OPCOUNT_EN
  // Count response handshakes, sticking at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      op_count <= '0;
    else if (rsp_valid && rsp_ready && (op_count != 16'hFFFF))
      op_count <= op_count + 16'd1;
  end
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_fpadd_sched.sv
// Bench for fpadd_sched: directed vector table, contention and reset-mid-op
// sequences, then randomized operations against a transaction-level model.
module tb_fpadd_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, dp_a, dp_b, dp_result, rsp_result;
  logic        en_mask, en_align, en_alu, en_normal, en_pack;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] op_count;
  logic [4:0]  ens;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;     // completed handshakes since last reset
  logic mdl_last = 1'b1; // model: port granted most recently

  always #5 clk = ~clk;

  fpadd_sched dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .dp_a(dp_a), .dp_b(dp_b),
    .en_mask(en_mask), .en_align(en_align), .en_alu(en_alu),
    .en_normal(en_normal), .en_pack(en_pack),
    .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .op_count(op_count)
  );

  assign ens = {en_pack, en_normal, en_alu, en_align, en_mask};

  // Stand-in for the adder: exact for 1.0+2.0, otherwise an operand hash.
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  assign dp_result = fmodel(dp_a, dp_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_count(input int n);
`ifdef FPADD_SCHED_OPCOUNT_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n > 0) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  // One full operation from an idle DUT: accept, five stages, response with
  // 'stall' cycles of backpressure. Junk requests are waved during the busy
  // stages and must be ignored.
  task automatic do_op(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic eid,
                       input logic [31:0] eres, input int stall);
    logic [31:0] ea, eb;
    ea = eid ? a1 : a0;
    eb = eid ? b1 : b0;
    mdl_last = eid;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    #1;
    chk("grant", {30'd0, req1_ready, req0_ready}, eid ? 32'd2 : 32'd1);
    chk("idle_enables", ens, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      #1;
      chk("stage_enable", ens, 32'(5'd1 << (k - 1)));
      chk("busy_ready", {req1_ready, req0_ready}, 0);
      chk("dp_a_hold", dp_a, ea);
      chk("dp_b_hold", dp_b, eb);
      chk("busy_rsp_valid", rsp_valid, 0);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = (stall == 0);
    #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, eid);
    chk("rsp_result", rsp_result, eres);
    chk("resp_enables", ens, 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      rsp_ready = (s == stall - 1);
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      #1;
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_id", rsp_id, eid);
      chk("stall_rsp_result", rsp_result, eres);
      chk("stall_ready", {req1_ready, req0_ready}, 0);
      chk("stall_enables", ens, 0);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    n_done++;
    #1;
    chk("rsp_done", rsp_valid, 0);
    chk("op_count", op_count, exp_count(n_done));
  endtask

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, b0, a1, b1;
    logic        eid;
    logic [31:0] eres;
    int          stall;
  } vec_t;

  vec_t tbl[6];
  logic exp_g[$];
  logic got_g[$];
  logic got_r[$];
  logic [31:0] got_res[$];

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

    // Reset state
    #12;
    chk("rst_dp_a", dp_a, 0);
    chk("rst_dp_b", dp_b, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_enables", ens, 0);
    @(negedge clk);
    reset = 1'b0;

    // Contention from reset: both valid continuously for four operations
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'h11112222; req0_b = 32'h33334444;
    req1_a = 32'h55556666; req1_b = 32'h77778888;
    for (int c = 0; c < 28; c++) begin
      #1;
      if (req0_ready && req1_ready) chk("both_ready", 1, 0);
      if (req0_ready || req1_ready) begin
        got_g.push_back(req1_ready);
        exp_g.push_back(!mdl_last);
        mdl_last = !mdl_last;
      end
      if (rsp_valid && rsp_ready) begin
        got_r.push_back(rsp_id);
        got_res.push_back(rsp_result);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_done += 4;
    chk("contention_grants", got_g.size(), 4);
    chk("contention_rsps", got_r.size(), 4);
    for (int i = 0; i < 4 && i < got_g.size() && i < got_r.size(); i++) begin
      chk("contention_grant_id", got_g[i], (i % 2));
      chk("contention_rsp_id", got_r[i], (i % 2));
      chk("contention_result", got_res[i],
          (i % 2) ? fmodel(32'h55556666, 32'h77778888) : fmodel(32'h11112222, 32'h33334444));
    end
    if (exp_g.size() == 4) mdl_last = 1'b1;

    // Directed vector table (model last grant = 1 entering here)
    tbl[0] = '{1'b1, 1'b0, 32'h3F800000, 32'h40000000, 32'hDEADBEEF, 32'h0, 1'b0, 32'h40400000, 0};
    tbl[1] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h01234567, 32'h89ABCDEF, 1'b1, fmodel(32'h01234567, 32'h89ABCDEF), 5};
    tbl[2] = '{1'b1, 1'b1, 32'hAAAA5555, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h1, 1'b0, fmodel(32'hAAAA5555, 32'h0F0F0F0F), 1};
    tbl[3] = '{1'b1, 1'b1, 32'h7F800000, 32'hFF800000, 32'h00000001, 32'h80000000, 1'b1, fmodel(32'h00000001, 32'h80000000), 0};
    tbl[4] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'hC0490FDB, 32'h3F000000, 1'b1, fmodel(32'hC0490FDB, 32'h3F000000), 2};
    tbl[5] = '{1'b1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 1'b0, fmodel(32'h12345678, 32'h9ABCDEF0), 0};
    for (int i = 0; i < 6; i++)
      do_op(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
            tbl[i].eid, tbl[i].eres, tbl[i].stall);

    // Reset while in ALU: everything clears at once, the op never responds
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h40A00000; req0_b = 32'h41200000;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_reset_alu", ens, 5'b00100);
    reset = 1'b1;
    #1;
    chk("midrst_enables", ens, 0);
    chk("midrst_dp_a", dp_a, 0);
    chk("midrst_dp_b", dp_b, 0);
    chk("midrst_rsp_result", rsp_result, 0);
    chk("midrst_rsp_id", rsp_id, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    n_done = 0; mdl_last = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_quiet", {27'd0, rsp_valid, ens}, 0);
    end
    do_op(1'b1, 1'b1, 32'h3F800000, 32'h40000000, 32'h1, 32'h2, 1'b0, 32'h40400000, 0);
    do_op(1'b1, 1'b1, 32'h3, 32'h4, 32'h5, 32'h6, 1'b1, fmodel(32'h5, 32'h6), 0);
    do_op(1'b0, 1'b1, 32'h7, 32'h8, 32'h9, 32'hA, 1'b1, fmodel(32'h9, 32'hA), 1);

    // Randomized operations against the round-robin model
    for (int r = 0; r < 15; r++) begin
      logic [1:0]  v;
      logic        eid;
      logic [31:0] a0, b0, a1, b1;
      v  = 2'($urandom_range(1, 3));
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      eid = (v == 2'b11) ? !mdl_last : v[1];
      do_op(v[0], v[1], a0, b0, a1, b1, eid,
            eid ? fmodel(a1, b1) : fmodel(a0, b0), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpadd_sched.md
FPADD_SCHED -- requirements
Module: fpadd_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester 0/1 has an operand pair.
REQ-004 SHALL have ports req0_ready / req1_ready, output, 1 bit each: grant/accept strobe to requester 0/1.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32 bits each: IEEE-754 single operands.
REQ-006 SHALL have ports dp_a / dp_b, output, 32 bits each: registered operands driven to the shared adder datapath A/B.
REQ-007 SHALL have ports en_mask, en_align, en_alu, en_normal, en_pack, output, 1 bit each: datapath stage-register enables.
REQ-008 SHALL have port dp_result, input, 32 bits: packed Result from the datapath.
REQ-009 SHALL have ports rsp_valid (output, 1 bit), rsp_ready (input, 1 bit), rsp_id (output, 1 bit), rsp_result (output, 32 bits): response channel tagged with requester id.
REQ-010 SHALL have port op_count, output, 16 bits: completed-operation counter.

Function
REQ-011 SHALL run FSM states IDLE, MASK, ALIGN, ALU, NORMAL, PACK, RESP.
REQ-012 In IDLE, with any reqN_valid high, SHALL assert exactly one reqN_ready combinationally, latch that requester's a/b into dp_a/dp_b and its id, and go to MASK next cycle.
REQ-013 SHALL arbitrate round-robin: on both valid, grant the port not granted last; last_grant resets to 1 (port 0 wins first tie).
REQ-014 SHALL assert reqN_ready only in IDLE; never both in one cycle.
REQ-015 SHALL advance MASK->ALIGN->ALU->NORMAL->PACK->RESP unconditionally, one cycle each.
REQ-016 SHALL assert exactly one stage enable, matching the current state (en_mask in MASK ... en_pack in PACK); all enables low in IDLE and RESP.
REQ-017 SHALL capture dp_result into rsp_result on the PACK->RESP edge.
REQ-018 In RESP SHALL hold rsp_valid high with stable rsp_id/rsp_result until rsp_ready high; then go to IDLE.
REQ-019 Latency: accept at cycle N -> rsp_valid first high at N+6; minimum spacing between accepts 7 cycles.
REQ-020 SHALL hold dp_a/dp_b stable from accept until next accept.
REQ-021 Requests deasserted before grant SHALL be dropped silently; no state change.

Reset
REQ-022 On reset, regardless of state (including mid-operation), SHALL go to IDLE, clear dp_a, dp_b, rsp_result, rsp_id, op_count to 0, last_grant to 1, and deassert all ready, enable and rsp_valid outputs.
REQ-023 Operation in flight at reset SHALL be discarded with no response.

Configuration
REQ-024 With macro FPADD_SCHED_OPCOUNT_EN defined, op_count SHALL increment by 1 on each rsp_valid&&rsp_ready handshake, saturating at 16'hFFFF.
REQ-025 Without FPADD_SCHED_OPCOUNT_EN, op_count SHALL be constant 0 and the counter SHALL not be synthesized.

Verification
REQ-026 Single op: req0 a=32'h3F800000, b=32'h40000000, dp_result model returns 32'h40400000 -> rsp_valid at accept+6, rsp_id=0, rsp_result=32'h40400000.
REQ-027 Contention: both valid continuously from reset -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-028 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_result stable, both reqN_ready low, FSM stays RESP.
REQ-029 Stage sequencing: after accept, en_mask..en_pack each high exactly once in order, one-hot, cycles N+1..N+5.
REQ-030 Reset mid-op: assert reset in ALU state -> all outputs cleared immediately, no rsp_valid afterwards; next request served normally.
REQ-031 Counter: with FPADD_SCHED_OPCOUNT_EN, 3 completed ops -> op_count=3; without macro -> op_count=0.
